// File: rtl/fft_rd_pkg.sv
//------------------------------------------------------------------------------
// Module  : fft_rd_pkg
// Purpose : Shared state encoding, flush depth and width helper for the reader.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package fft_rd_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      COLLECT = 3'd2,
      FLUSH   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int FLUSH_CYC = 3;

   function automatic int PWR_W(input int data_w);
      return 2 * data_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bin_power_pipe.sv
//------------------------------------------------------------------------------
// Module  : bin_power_pipe
// Purpose : Three-stage bin power pipeline (re^2 + im^2), fixed 3-cycle latency.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin_power_pipe
   import fft_rd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        vld_i,
   input  logic [DATA_W-1:0]           re_i,
   input  logic [DATA_W-1:0]           im_i,
   input  logic [IDX_W-1:0]            idx_i,
   output logic                        vld_o,
   output logic [PWR_W(DATA_W)-1:0]    pwr_o,
   output logic [IDX_W-1:0]            idx_o
);

   localparam int PW = PWR_W(DATA_W);

   logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
   logic [IDX_W-1:0]         s1_idx_q, s2_idx_q, s3_idx_q;
   logic                     s1_vld_q, s2_vld_q, s3_vld_q;
   logic signed [PW-1:0]     s2_re2_q, s2_im2_q;
   logic [PW-1:0]            s3_pwr_q;
   logic signed [PW-1:0]     w_re_x, w_im_x;

   // Explicit sign extension keeps each square a full-width signed product.
   assign w_re_x = {{DATA_W{s1_re_q[DATA_W-1]}}, s1_re_q};
   assign w_im_x = {{DATA_W{s1_im_q[DATA_W-1]}}, s1_im_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_re_q  <= '0;
         s1_im_q  <= '0;
         s1_idx_q <= '0;
         s1_vld_q <= 1'b0;
         s2_re2_q <= '0;
         s2_im2_q <= '0;
         s2_idx_q <= '0;
         s2_vld_q <= 1'b0;
         s3_pwr_q <= '0;
         s3_idx_q <= '0;
         s3_vld_q <= 1'b0;
      end else begin
         s1_re_q  <= re_i;
         s1_im_q  <= im_i;
         s1_idx_q <= idx_i;
         s1_vld_q <= vld_i;
         s2_re2_q <= w_re_x * w_re_x;
         s2_im2_q <= w_im_x * w_im_x;
         s2_idx_q <= s1_idx_q;
         s2_vld_q <= s1_vld_q;
         s3_pwr_q <= $unsigned(s2_re2_q) + $unsigned(s2_im2_q);
         s3_idx_q <= s2_idx_q;
         s3_vld_q <= s2_vld_q;
      end
   end

   assign vld_o = s3_vld_q;
   assign pwr_o = s3_pwr_q;
   assign idx_o = s3_idx_q;

endmodule

`default_nettype wire

// File: rtl/fft_peak_reader.sv
//------------------------------------------------------------------------------
// Module  : fft_peak_reader
// Purpose : Unloads one COREFFT result frame, reports peak bin and total power.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fft_peak_reader
   import fft_rd_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int POINTS  = 1024,
   parameter int IDX_W   = 10,
   parameter bit SKIP_DC = 1'b1
) (
   input  logic                        CLK,
   input  logic                        NGRST,
   input  logic                        ARM,
   input  logic                        OUTP_READY,
   input  logic                        DATAO_VALID,
   input  logic [DATA_W-1:0]           DATAO_RE,
   input  logic [DATA_W-1:0]           DATAO_IM,
   output logic                        READ_OUTP,
   output logic                        BUSY,
   output logic                        RESULT_VALID,
   output logic [IDX_W-1:0]            PEAK_IDX,
   output logic [2*DATA_W-1:0]         PEAK_PWR,
   output logic [2*DATA_W+IDX_W-1:0]   SUM_PWR,
   output logic                        OVERRUN
);

   localparam int PW = PWR_W(DATA_W);
   localparam int SW = PW + IDX_W;
   localparam logic [IDX_W:0] LAST_BEAT  = (IDX_W+1)'(POINTS - 1);
   localparam logic [1:0]     FLUSH_LAST = 2'(FLUSH_CYC - 1);

   state_t            state_q, state_d;
   logic [IDX_W:0]    beat_cnt_q, beat_cnt_d;
   logic [1:0]        flush_cnt_q, flush_cnt_d;
   logic              accept;

   logic              found_q, found_d;
   logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
   logic [PW-1:0]     peak_pwr_q, peak_pwr_d;
   logic [SW-1:0]     sum_q, sum_d;

   logic [IDX_W-1:0]  out_idx_q;
   logic [PW-1:0]     out_pwr_q;
   logic [SW-1:0]     out_sum_q;
   logic              overrun_q;

   logic              p_vld;
   logic [PW-1:0]     p_pwr;
   logic [IDX_W-1:0]  p_idx;
   logic              eligible;

   bin_power_pipe #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_pipe (
      .clk_i  (CLK),
      .rst_ni (NGRST),
      .vld_i  (accept),
      .re_i   (DATAO_RE),
      .im_i   (DATAO_IM),
      .idx_i  (beat_cnt_q[IDX_W-1:0]),
      .vld_o  (p_vld),
      .pwr_o  (p_pwr),
      .idx_o  (p_idx)
   );

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      flush_cnt_d = flush_cnt_q;
      accept      = 1'b0;
      case (state_q)
         IDLE:    if (ARM && OUTP_READY) state_d = REQ;
         REQ: begin
            beat_cnt_d = '0;
            state_d    = COLLECT;
         end
         COLLECT: begin
            flush_cnt_d = '0;
            if (DATAO_VALID) begin
               accept     = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) state_d = FLUSH;
            end
         end
         FLUSH: begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FLUSH_LAST) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // DC bin still feeds the sum; it is only kept out of the peak search.
   assign eligible = p_vld && !(SKIP_DC && (p_idx == '0));

   always_comb begin
      found_d    = found_q;
      peak_idx_d = peak_idx_q;
      peak_pwr_d = peak_pwr_q;
      sum_d      = sum_q;
      if (state_q == REQ) begin
         found_d    = 1'b0;
         peak_idx_d = '0;
         peak_pwr_d = '0;
         sum_d      = '0;
      end else if (p_vld) begin
         sum_d = sum_q + SW'(p_pwr);
         if (eligible && (!found_q || (p_pwr > peak_pwr_q))) begin
            found_d    = 1'b1;
            peak_idx_d = p_idx;
            peak_pwr_d = p_pwr;
         end
      end
   end

   always_ff @(posedge CLK or negedge NGRST) begin
      if (!NGRST) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
         found_q     <= 1'b0;
         peak_idx_q  <= '0;
         peak_pwr_q  <= '0;
         sum_q       <= '0;
         out_idx_q   <= '0;
         out_pwr_q   <= '0;
         out_sum_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         found_q     <= found_d;
         peak_idx_q  <= peak_idx_d;
         peak_pwr_q  <= peak_pwr_d;
         sum_q       <= sum_d;
         // Publish on the edge entering DONE so outputs change with RESULT_VALID.
         if ((state_q == FLUSH) && (state_d == DONE)) begin
            out_idx_q <= peak_idx_d;
            out_pwr_q <= peak_pwr_d;
            out_sum_q <= sum_d;
         end
         if (DATAO_VALID && (state_q != COLLECT)) overrun_q <= 1'b1;
      end
   end

   assign READ_OUTP    = (state_q == REQ);
   assign BUSY         = (state_q != IDLE);
   assign RESULT_VALID = (state_q == DONE);
   assign PEAK_IDX     = out_idx_q;
   assign PEAK_PWR     = out_pwr_q;
   assign SUM_PWR      = out_sum_q;
   assign OVERRUN      = overrun_q;

endmodule

`default_nettype wire
